// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit: one outstanding data-cache access per request (option MEM_MISALIGN_TRAP_EN)
module mem_access_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_load_type,
    output logic        cache_req,
    output logic [31:0] cache_addr,
    output logic [3:0]  cache_we,
    output logic [31:0] cache_wdata,
    input  logic        cache_ack,
    input  logic [31:0] cache_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [1:0]  wb_addr,
    output logic [2:0]  wb_load_type,
    output logic        stall,
    output logic        misalign
);

    localparam logic [2:0] NOREGWRITE = 3'b000;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state, state_next;
    logic        handshake;
    logic        bad_align;
    logic        accept;
    logic [1:0]  eff_off;
    logic [3:0]  we_next;
    logic [31:0] wdata_next;
    logic        store_q;
    logic [1:0]  off_q;
    logic [2:0]  type_q;

    assign handshake = req_valid & req_ready;
    assign accept    = handshake & ~bad_align;

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        bad_align = 1'b0;
        eff_off   = req_addr[1:0];
        if (req_size == 2'b01)
            bad_align = req_addr[0];
        else if (req_size[1])
            bad_align = |req_addr[1:0];
    end
`else
    // Misaligned halves/words are silently aligned down instead of trapping.
    always_comb begin
        bad_align = 1'b0;
        eff_off   = req_addr[1:0];
        if (req_size == 2'b01)
            eff_off = {req_addr[1], 1'b0};
        else if (req_size[1])
            eff_off = 2'b00;
    end
`endif

    always_comb begin
        we_next    = 4'b1111;
        wdata_next = req_wdata;
        case (req_size)
            2'b00: begin
                we_next    = 4'b0001 << eff_off;
                wdata_next = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                we_next    = 4'b0011 << {eff_off[1], 1'b0};
                wdata_next = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
        if (!req_store)
            we_next = 4'b0000;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = WAIT;
            WAIT:    if (cache_ack) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    assign req_ready = (state == IDLE);
    assign cache_req = (state == WAIT);
    assign stall     = (state == WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_addr  <= 32'd0;
            cache_we    <= 4'd0;
            cache_wdata <= 32'd0;
            store_q     <= 1'b0;
            off_q       <= 2'd0;
            type_q      <= NOREGWRITE;
        end else if (accept) begin
            cache_addr  <= {req_addr[31:2], 2'b00};
            cache_we    <= we_next;
            cache_wdata <= wdata_next;
            store_q     <= req_store;
            off_q       <= req_addr[1:0];
            type_q      <= req_store ? NOREGWRITE : req_load_type;
        end
    end

    // Result fields only move on a completion so the extend stage sees them stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid     <= 1'b0;
            wb_data      <= 32'd0;
            wb_addr      <= 2'd0;
            wb_load_type <= NOREGWRITE;
            misalign     <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            misalign <= handshake & bad_align;
            if (state == WAIT && cache_ack) begin
                wb_valid     <= 1'b1;
                wb_data      <= store_q ? 32'd0 : cache_rdata;
                wb_addr      <= off_q;
                wb_load_type <= type_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'd0;
    logic        req_store = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [2:0]  req_load_type = 3'd0;
    logic        cache_req;
    logic [31:0] cache_addr;
    logic [3:0]  cache_we;
    logic [31:0] cache_wdata;
    logic        cache_ack = 1'b0;
    logic [31:0] cache_rdata = 32'd0;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [1:0]  wb_addr;
    logic [2:0]  wb_load_type;
    logic        stall;
    logic        misalign;

    int checks = 0;
    int failures = 0;
    logic [31:0] last_wb_data;

    localparam logic [2:0] NOREGWRITE = 3'b000;
    localparam logic [2:0] LT_LB      = 3'b001;
    localparam logic [2:0] LT_LW      = 3'b011;

    mem_access_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_store(req_store), .req_size(req_size), .req_wdata(req_wdata),
        .req_load_type(req_load_type),
        .cache_req(cache_req), .cache_addr(cache_addr), .cache_we(cache_we),
        .cache_wdata(cache_wdata), .cache_ack(cache_ack), .cache_rdata(cache_rdata),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_addr(wb_addr),
        .wb_load_type(wb_load_type), .stall(stall), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single cycle; returns #1 after the accepting edge.
    task automatic issue(input logic [31:0] addr, input logic st, input logic [1:0] sz,
                         input logic [31:0] wd, input logic [2:0] lt);
        check("ready_before_issue", {31'd0, req_ready}, 32'd1);
        req_valid     = 1'b1;
        req_addr      = addr;
        req_store     = st;
        req_size      = sz;
        req_wdata     = wd;
        req_load_type = lt;
        next_cycle();
        req_valid = 1'b0;
    endtask

    task automatic ack_pulse(input logic [31:0] rd);
        cache_ack   = 1'b1;
        cache_rdata = rd;
        next_cycle();
        cache_ack   = 1'b0;
    endtask

    initial begin
        #3;
        check("rst_ready",     {31'd0, req_ready}, 32'd1);
        check("rst_cache_req", {31'd0, cache_req}, 32'd0);
        check("rst_stall",     {31'd0, stall},     32'd0);
        check("rst_wb_valid",  {31'd0, wb_valid},  32'd0);
        check("rst_wb_data",   wb_data,            32'd0);
        check("rst_cache_addr", cache_addr,        32'd0);
        check("rst_cache_we",  {28'd0, cache_we},  32'd0);
        check("rst_misalign",  {31'd0, misalign},  32'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // LB at 0x1003, ack in the second WAIT cycle
        issue(32'h0000_1003, 1'b0, 2'b00, 32'd0, LT_LB);
        check("lb_cache_req",  {31'd0, cache_req}, 32'd1);
        check("lb_cache_addr", cache_addr,         32'h0000_1000);
        check("lb_cache_we",   {28'd0, cache_we},  32'd0);
        check("lb_stall1",     {31'd0, stall},     32'd1);
        check("lb_ready_low",  {31'd0, req_ready}, 32'd0);
        next_cycle();
        check("lb_stall2",     {31'd0, stall},     32'd1);
        check("lb_addr_hold",  cache_addr,         32'h0000_1000);
        check("lb_no_wb_yet",  {31'd0, wb_valid},  32'd0);
        ack_pulse(32'h8011_2233);
        check("lb_wb_valid",   {31'd0, wb_valid},  32'd1);
        check("lb_wb_data",    wb_data,            32'h8011_2233);
        check("lb_wb_addr",    {30'd0, wb_addr},   32'd3);
        check("lb_wb_type",    {29'd0, wb_load_type}, {29'd0, LT_LB});
        check("lb_stall_off",  {31'd0, stall},     32'd0);
        next_cycle();
        check("lb_wb_pulse",   {31'd0, wb_valid},  32'd0);
        check("lb_wb_hold",    wb_data,            32'h8011_2233);

        // SH of 0xABCD at 0x2002
        issue(32'h0000_2002, 1'b1, 2'b01, 32'h0000_ABCD, LT_LW);
        check("sh_cache_we",    {28'd0, cache_we}, 32'b1100);
        check("sh_cache_wdata", cache_wdata,       32'hABCD_ABCD);
        check("sh_cache_addr",  cache_addr,        32'h0000_2000);
        ack_pulse(32'hFFFF_FFFF);
        check("sh_wb_valid",    {31'd0, wb_valid}, 32'd1);
        check("sh_wb_type",     {29'd0, wb_load_type}, {29'd0, NOREGWRITE});
        check("sh_wb_data",     wb_data,           32'd0);

        // SB of 0xA5 at 0x6001
        issue(32'h0000_6001, 1'b1, 2'b00, 32'h1234_56A5, LT_LB);
        check("sb_cache_we",    {28'd0, cache_we}, 32'b0010);
        check("sb_cache_wdata", cache_wdata,       32'hA5A5_A5A5);
        ack_pulse(32'd0);

        // SW at 0x3000, minimum latency
        issue(32'h0000_3000, 1'b1, 2'b10, 32'h1234_5678, LT_LW);
        check("sw_cache_we",    {28'd0, cache_we}, 32'b1111);
        check("sw_cache_wdata", cache_wdata,       32'h1234_5678);
        check("sw_wb_t1",       {31'd0, wb_valid}, 32'd0);
        ack_pulse(32'd0);
        check("sw_wb_t2",       {31'd0, wb_valid}, 32'd1);
        check("sw_ready_t2",    {31'd0, req_ready}, 32'd1);
        next_cycle();

        // Reset while waiting, then a late ack
        issue(32'h0000_5000, 1'b0, 2'b10, 32'd0, LT_LW);
        check("rw_cache_req",   {31'd0, cache_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rw_req_async",   {31'd0, cache_req}, 32'd0);
        check("rw_stall_async", {31'd0, stall},     32'd0);
        check("rw_addr_async",  cache_addr,         32'd0);
        next_cycle();
        rst_n = 1'b1;
        ack_pulse(32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) begin
            check("rw_no_wb",   {31'd0, wb_valid},  32'd0);
            check("rw_no_req",  {31'd0, cache_req}, 32'd0);
            next_cycle();
        end
        last_wb_data = 32'd0;

        // LW at 0x4001
        issue(32'h0000_4001, 1'b0, 2'b10, 32'd0, LT_LW);
`ifdef MEM_MISALIGN_TRAP_EN
        check("lwm_no_req",    {31'd0, cache_req}, 32'd0);
        check("lwm_misalign",  {31'd0, misalign},  32'd1);
        check("lwm_ready",     {31'd0, req_ready}, 32'd1);
        next_cycle();
        check("lwm_pulse",     {31'd0, misalign},  32'd0);
        check("lwm_no_wb",     {31'd0, wb_valid},  32'd0);
`else
        check("lwm_cache_req", {31'd0, cache_req}, 32'd1);
        check("lwm_cache_addr", cache_addr,        32'h0000_4000);
        check("lwm_misalign",  {31'd0, misalign},  32'd0);
        ack_pulse(32'hDEAD_BEEF);
        check("lwm_wb_valid",  {31'd0, wb_valid},  32'd1);
        check("lwm_wb_data",   wb_data,            32'hDEAD_BEEF);
        last_wb_data = 32'hDEAD_BEEF;
        next_cycle();
`endif

        // Stray ack while idle
        ack_pulse(32'h0000_0055);
        check("stray_no_wb",   {31'd0, wb_valid},  32'd0);
        check("stray_stall",   {31'd0, stall},     32'd0);
        check("stray_ready",   {31'd0, req_ready}, 32'd1);
        check("stray_wb_data", wb_data,            last_wb_data);
        next_cycle();
        check("stray_no_wb2",  {31'd0, wb_valid},  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port: clk  in  1  core clock, all state updates on rising edge.
REQ-002 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: req_valid  in  1  EX stage presents a load/store.
REQ-004 SHALL have port: req_ready  out  1  unit can accept; handshake = req_valid & req_ready.
REQ-005 SHALL have port: req_addr  in  32  byte address.
REQ-006 SHALL have port: req_store  in  1  1 = store, 0 = load.
REQ-007 SHALL have port: req_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-008 SHALL have port: req_wdata  in  32  store data, LSB-justified.
REQ-009 SHALL have port: req_load_type  in  3  load-type code (Parameters.v encoding), forwarded to the extend stage.
REQ-010 SHALL have port: cache_req  out  1  request to data cache, held until ack.
REQ-011 SHALL have port: cache_addr  out  32  word-aligned address (bits [1:0] = 00).
REQ-012 SHALL have port: cache_we  out  4  byte write enables; 0000 for loads.
REQ-013 SHALL have port: cache_wdata  out  32  lane-replicated store data.
REQ-014 SHALL have port: cache_ack  in  1  one-cycle completion pulse from cache.
REQ-015 SHALL have port: cache_rdata  in  32  read word, valid with cache_ack.
REQ-016 SHALL have port: wb_valid  out  1  one-cycle pulse: result for the extend stage.
REQ-017 SHALL have port: wb_data  out  32  raw read word (unextended).
REQ-018 SHALL have port: wb_addr  out  2  byte offset req_addr[1:0].
REQ-019 SHALL have port: wb_load_type  out  3  load type; NOREGWRITE code for stores.
REQ-020 SHALL have port: stall  out  1  pipeline hold, high while state = WAIT.
REQ-021 SHALL have port: misalign  out  1  misaligned-access pulse (see Configuration).

Function
REQ-022 SHALL implement FSM states IDLE and WAIT; req_ready = 1 only in IDLE.
REQ-023 SHALL, on handshake in IDLE, register address, enables, data, offset and type, and enter WAIT next cycle.
REQ-024 SHALL assert cache_req only in WAIT, with cache_addr/we/wdata held stable until cache_ack.
REQ-025 SHALL ignore cache_ack while in IDLE.
REQ-026 SHALL, on cache_ack in WAIT, capture cache_rdata, return to IDLE, and pulse wb_valid for exactly one cycle on the following cycle.
REQ-027 SHALL have minimum latency: handshake at T, cache_req at T+1, ack at T+1, wb_valid at T+2; unit can accept again at T+2.
REQ-028 SHALL hold wb_data/wb_addr/wb_load_type stable until the next wb_valid pulse.
REQ-029 SHALL generate byte enables: byte -> 0001 << addr[1:0], wdata = {4{wdata[7:0]}}; half -> 0011 << (2*addr[1]), wdata = {2{wdata[15:0]}}; word -> 1111, wdata unchanged.
REQ-030 SHALL, for stores, set wb_load_type = NOREGWRITE and wb_data = 0.

Reset
REQ-031 SHALL, on rst_n low, immediately force state IDLE, and cache_req, cache_we, wb_valid, stall and misalign to 0, and wb_data, cache_addr and cache_wdata to 0.
REQ-032 SHALL, on reset during WAIT, abandon the access: no wb_valid is produced, and a late cache_ack after release is ignored.

Configuration
REQ-033 SHALL, with MEM_MISALIGN_TRAP_EN defined, detect a half with addr[0]=1 or a word with addr[1:0]!=00 at handshake, issue no cache request, stay in IDLE, and pulse misalign for one cycle (wb_valid stays 0).
REQ-034 SHALL, without MEM_MISALIGN_TRAP_EN, tie misalign to 0 and force offending low address bits to 0 (half: addr[0]; word: addr[1:0]) before enable generation.

Verification
REQ-035 SHALL cover: LB at 0x1003, ack after 2 cycles with rdata 0x80112233 -> cache_addr 0x1000, cache_we 0000, stall 2 cycles, wb_valid pulse with wb_data 0x80112233, wb_addr 11.
REQ-036 SHALL cover: SH of 0x0000ABCD at 0x2002 -> cache_we 1100, cache_wdata 0xABCDABCD, wb_load_type NOREGWRITE.
REQ-037 SHALL cover: SW at 0x3000, ack in the first WAIT cycle -> wb_valid exactly at T+2, req_ready high at T+2.
REQ-038 SHALL cover: rst_n low while in WAIT, then an ack after release -> cache_req drops asynchronously, no wb_valid at any cycle.
REQ-039 SHALL cover: LW at 0x4001 -> with macro, misalign pulse and no cache_req; without macro, cache_addr 0x4000 and normal completion.
REQ-040 SHALL cover: stray cache_ack in IDLE -> no state change, no wb_valid.
